out_port_arb: RTL and testbench
===============================

// Module: out_port_arb
// PURPOSE
//  Per-output-port arbiter: one instance per egress port. Collects request pulses from the PORTNUM
//  input channel requesters, grants one (o_resp) or rejects (o_nresp) each, and locks the port to
//  the winner until its end-of-packet. o_owner drives the port's write-side data mux.
// PARAMETERS
//  PORTNUM      16    number of requesting input channels (power of two)
//  WDOG_CYCLES  256   idle-owner timeout in cycles, used only with OUT_ARB_WDOG_EN
// PORTS
//  i_clk         in   1                    clock
//  i_rst         in   1                    synchronous, active-high reset
//  i_req         in   PORTNUM              request pulse per channel
//  i_port_ready  in   1                    port can accept a new packet (space/ready from cache side)
//  i_data_vld    in   PORTNUM              per-channel data valid, only the owner's bit is used
//  i_eop         in   PORTNUM              per-channel end-of-packet, only the owner's bit is used
//  o_resp        out  PORTNUM              one-cycle grant pulse, one-hot or zero
//  o_nresp       out  PORTNUM              one-cycle reject pulse, any number of bits
//  o_owner       out  $clog2(PORTNUM)      index of the channel owning the port
//  o_owner_vld   out  1                    port locked (o_owner meaningful)
//  o_wdog_err    out  1                    one-cycle pulse on a watchdog release (0 when macro off)
// BEHAVIOUR
//  - Reset (i_rst=1 at an edge): state IDLE; rr_ptr=PORTNUM-1, so channel 0 has top priority first.
//    All outputs are 0. Reset takes priority over every event, including a mid-packet lock.
//  - State machine S_IDLE / S_GRANT / S_BUSY, registered. All outputs are registered.
//  - S_IDLE: with i_req!=0 at edge t:
//      - i_port_ready=1: winner = first set bit searching rr_ptr+1 upward, wrapping modulo PORTNUM.
//        At t+1: o_resp[winner]=1, o_nresp = i_req & ~winner_onehot, o_owner=winner, o_owner_vld=1,
//        rr_ptr=winner, state S_GRANT.
//      - i_port_ready=0: at t+1 o_nresp=i_req; stay IDLE; rr_ptr unchanged.
//  - S_GRANT: lasts one cycle, then S_BUSY. o_resp returns to 0.
//  - S_BUSY: on i_eop[o_owner]=1 -> S_IDLE next cycle; o_owner_vld=0 and o_owner keeps its value.
//    A new request is arbitrated no earlier than the cycle after the return to IDLE.
//  - Request while not IDLE (GRANT/BUSY): rejected, o_nresp[k]=1 on the next cycle, including a
//    request from the owner itself. i_eop on the same edge does not rescue it.
//  - eop from a non-owner channel is ignored. i_eop[o_owner] in S_GRANT is also accepted: go IDLE.
//  - Only the latency-1 reply is required: every request bit gets exactly one resp-or-nresp pulse
//    the cycle after it is sampled. No request is queued across cycles.
//  - Round-robin index arithmetic is done in $clog2(PORTNUM) bits; wrap is implicit (15+1 -> 0).
// CONFIGURATION
//  - OUT_ARB_WDOG_EN defined: in S_BUSY a counter of cycles with i_data_vld[o_owner]=0 runs.
//    The counter clears on any owner valid. When it reaches WDOG_CYCLES-1:
//      - the port is released (-> IDLE, o_owner_vld=0);
//      - o_wdog_err pulses for 1 cycle.
//  - OUT_ARB_WDOG_EN undefined: no counter. A lock is released only by i_eop or reset, and
//    o_wdog_err is tied to 0.
// STRUCTURE
//  - mpc_pkg holds:
//      - typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} arb_state_t;
//      - localparam PORTNUM_DEF=16 and PORTIDW=$clog2(PORTNUM_DEF).
//  - Sub-module rr_arb, combinational:
//      - inputs: request vector, rr_ptr;
//      - outputs: one-hot grant, grant index, any_vld.
//  - The FSM, output registers and watchdog live in out_port_arb.
// TESTING
//  1 Reset then i_req=16'h0001, ready=1 -> next cycle o_resp=16'h0001, o_owner=0, o_owner_vld=1.
//  2 In IDLE, rr_ptr=0, i_req=16'h8003 -> o_resp=16'h0002, o_nresp=16'h8001. Next contest
//    after release with i_req=16'h8001 -> o_resp=16'h8000.
//  3 Owner=5 in BUSY, i_req=16'h0010 -> o_nresp=16'h0010. i_eop[5] -> o_owner_vld=0 next cycle.
//    Re-request of 16'h0010 -> o_resp=16'h0010.
//  4 i_port_ready=0, i_req=16'hFFFF -> o_nresp=16'hFFFF, o_resp=0, state stays IDLE.
//  5 i_eop[3] pulsed while owner=5 -> ignored, lock held. i_rst=1 mid-packet -> all outputs 0
//    next cycle, channel 0 wins the next contest.
//  6 WDOG on, WDOG_CYCLES=8, owner silent 8 cycles -> o_wdog_err pulse, o_owner_vld=0.
//    WDOG off -> lock held after 1000 silent cycles.

Source files
------------

// File: rtl/out_port_arb_pkg.sv
// Shared types and defaults for the per-egress-port arbiter slice.
package mpc_pkg;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} arb_state_t;

   localparam int PORTNUM_DEF = 16;
   localparam int PORTIDW     = $clog2(PORTNUM_DEF);

endpackage

// File: rtl/out_port_arb_if.sv
// Request/grant bundle between the input channels and one egress-port arbiter.
interface out_port_arb_if #(
   parameter int PORTNUM = 16
);
   logic [PORTNUM-1:0]         i_req;
   logic                       i_port_ready;
   logic [PORTNUM-1:0]         i_data_vld;
   logic [PORTNUM-1:0]         i_eop;
   logic [PORTNUM-1:0]         o_resp;
   logic [PORTNUM-1:0]         o_nresp;
   logic [$clog2(PORTNUM)-1:0] o_owner;
   logic                       o_owner_vld;
   logic                       o_wdog_err;

   modport slave (
      input  i_req, i_port_ready, i_data_vld, i_eop,
      output o_resp, o_nresp, o_owner, o_owner_vld, o_wdog_err
   );

   modport master (
      output i_req, i_port_ready, i_data_vld, i_eop,
      input  o_resp, o_nresp, o_owner, o_owner_vld, o_wdog_err
   );
endinterface

// File: rtl/out_port_arb_rr_arb.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
// Zero latency; no backpressure, the caller decides whether the pick is used.
module rr_arb
   import mpc_pkg::*;
#(
   parameter int PORTNUM = PORTNUM_DEF,
   localparam int IDW    = $clog2(PORTNUM)
) (
   input  logic [PORTNUM-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [PORTNUM-1:0] gnt_o,
   output logic [IDW-1:0]     idx_o,
   output logic               any_vld_o
);

   logic [IDW-1:0] cand;

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      idx_o     = '0;
      any_vld_o = 1'b0;
      cand      = '0;
      for (int k = PORTNUM; k >= 1; k--) begin
         cand = ptr_i + IDW'(k);
         if (req_i[cand]) begin
            idx_o     = cand;
            any_vld_o = 1'b1;
         end
      end
   end

   assign gnt_o = any_vld_o ? (PORTNUM'(1) << idx_o) : '0;

endmodule

// File: rtl/out_port_arb.sv
// Egress-port arbiter: grants/rejects each request one cycle after sampling and locks to the winner until eop.
// Requests arriving while locked or while i_port_ready=0 are rejected; optional idle-owner watchdog via OUT_ARB_WDOG_EN.
module out_port_arb
   import mpc_pkg::*;
#(
   parameter int PORTNUM     = PORTNUM_DEF,
   parameter int WDOG_CYCLES = 256
) (
   input  logic           i_clk,
   input  logic           i_rst,
   out_port_arb_if.slave  bus
);

   localparam int IDW = $clog2(PORTNUM);

   arb_state_t         state_q;
   logic [IDW-1:0]     rr_ptr_q;
   logic [PORTNUM-1:0] resp_q;
   logic [PORTNUM-1:0] nresp_q;
   logic [IDW-1:0]     owner_q;
   logic               owner_vld_q;

   logic [PORTNUM-1:0] resp_d;
   logic [IDW-1:0]     owner_d;
   logic               req_any;

   rr_arb #(.PORTNUM(PORTNUM)) u_rr_arb (
      .req_i     (bus.i_req),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (resp_d),
      .idx_o     (owner_d),
      .any_vld_o (req_any)
   );

`ifdef OUT_ARB_WDOG_EN
   localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   logic [CW-1:0] wdog_cnt_q;
   logic          wdog_err_q;
`else
   localparam int unused_wdog_cycles = WDOG_CYCLES;
   logic          unused_data_vld;
   assign unused_data_vld = ^bus.i_data_vld;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '1;
         resp_q      <= '0;
         nresp_q     <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
`ifdef OUT_ARB_WDOG_EN
         wdog_cnt_q  <= '0;
         wdog_err_q  <= 1'b0;
`endif
      end else begin
         resp_q  <= '0;
         nresp_q <= '0;
`ifdef OUT_ARB_WDOG_EN
         wdog_err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (req_any) begin
                  if (bus.i_port_ready) begin
                     resp_q      <= resp_d;
                     nresp_q     <= bus.i_req & ~resp_d;
                     owner_q     <= owner_d;
                     owner_vld_q <= 1'b1;
                     rr_ptr_q    <= owner_d;
                     state_q     <= S_GRANT;
`ifdef OUT_ARB_WDOG_EN
                     wdog_cnt_q  <= '0;
`endif
                  end else begin
                     nresp_q <= bus.i_req;
                  end
               end
            end
            S_GRANT: begin
               nresp_q <= bus.i_req;
               if (bus.i_eop[owner_q]) begin
                  owner_vld_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               // Locked: every request is rejected, even the owner's own.
               nresp_q <= bus.i_req;
               if (bus.i_eop[owner_q]) begin
                  owner_vld_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
`ifdef OUT_ARB_WDOG_EN
               else if (bus.i_data_vld[owner_q]) begin
                  wdog_cnt_q <= '0;
               end else if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
                  wdog_cnt_q  <= '0;
                  wdog_err_q  <= 1'b1;
                  owner_vld_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  wdog_cnt_q <= wdog_cnt_q + CW'(1);
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.o_resp      = resp_q;
   assign bus.o_nresp     = nresp_q;
   assign bus.o_owner     = owner_q;
   assign bus.o_owner_vld = owner_vld_q;
`ifdef OUT_ARB_WDOG_EN
   assign bus.o_wdog_err  = wdog_err_q;
`else
   assign bus.o_wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_arb.sv
// Directed scenarios plus randomized traffic for out_port_arb, checked against a behavioural lock/round-robin model.
module tb_out_port_arb;

   localparam int PN = 16;
   localparam int WD = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   out_port_arb_if #(.PORTNUM(PN)) bus();

   out_port_arb #(.PORTNUM(PN), .WDOG_CYCLES(WD)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: lock flag, owner, last winner, silent-cycle count.
   bit      m_locked, m_fresh;
   int      m_owner, m_last, m_silent;
   logic [PN-1:0] e_resp, e_nresp;
   logic [3:0]    e_owner;
   logic          e_vld, e_err;

   task automatic model_reset();
      m_locked = 0; m_fresh = 0; m_owner = 0; m_last = PN - 1; m_silent = 0;
      e_resp = '0; e_nresp = '0; e_owner = '0; e_vld = 0; e_err = 0;
   endtask

   task automatic model_edge(input logic [PN-1:0] req, input logic rdy,
                             input logic [PN-1:0] eop, input logic [PN-1:0] dvld);
      e_resp = '0; e_nresp = '0; e_err = 0;
      if (!m_locked) begin
         if (req != '0) begin
            if (rdy) begin
               int w;
               w = -1;
               for (int k = 1; k <= PN; k++)
                  if (w < 0 && req[(m_last + k) % PN]) w = (m_last + k) % PN;
               e_resp[w] = 1'b1;
               e_nresp   = req & ~e_resp;
               m_owner = w; m_last = w; m_locked = 1; m_fresh = 1; m_silent = 0;
            end else begin
               e_nresp = req;
            end
         end
      end else begin
         e_nresp = req;
         if (eop[m_owner]) begin
            m_locked = 0;
         end else if (!m_fresh) begin
`ifdef OUT_ARB_WDOG_EN
            if (dvld[m_owner]) m_silent = 0;
            else begin
               m_silent++;
               if (m_silent == WD) begin
                  m_locked = 0; e_err = 1; m_silent = 0;
               end
            end
`else
            if (dvld[m_owner] === 1'bx) m_silent = 0;
`endif
         end
         m_fresh = 0;
      end
      e_vld   = m_locked;
      e_owner = 4'(m_owner);
   endtask

   task automatic cycle(input logic [PN-1:0] req, input logic rdy,
                        input logic [PN-1:0] eop, input logic [PN-1:0] dvld);
      bus.i_req = req; bus.i_port_ready = rdy; bus.i_eop = eop; bus.i_data_vld = dvld;
      model_edge(req, rdy, eop, dvld);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_req = '0; bus.i_port_ready = 1'b0; bus.i_eop = '0; bus.i_data_vld = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus.o_resp, bus.o_nresp} !== 32'h0) begin
         n_errors++; $display("FAIL reset_resp_nresp got %h/%h want 0/0", bus.o_resp, bus.o_nresp);
      end
      n_checks++;
      if ({bus.o_owner, bus.o_owner_vld, bus.o_wdog_err} !== 6'h0) begin
         n_errors++; $display("FAIL reset_owner got owner=%0d vld=%b err=%b want 0", bus.o_owner, bus.o_owner_vld, bus.o_wdog_err);
      end
   endtask

   task automatic test_first_grant();
      cycle(16'h0001, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_resp !== 16'h0001 || bus.o_nresp !== 16'h0000) begin
         n_errors++; $display("FAIL first_grant_resp got %h/%h want 0001/0000", bus.o_resp, bus.o_nresp);
      end
      n_checks++;
      if (bus.o_owner !== 4'd0 || bus.o_owner_vld !== 1'b1) begin
         n_errors++; $display("FAIL first_grant_owner got %0d/%b want 0/1", bus.o_owner, bus.o_owner_vld);
      end
      cycle('0, 1'b1, 16'h0001, '0);
      n_checks++;
      if (bus.o_owner_vld !== 1'b0 || bus.o_resp !== 16'h0) begin
         n_errors++; $display("FAIL eop_in_grant got vld=%b resp=%h want 0/0000", bus.o_owner_vld, bus.o_resp);
      end
   endtask

   task automatic test_rr_priority();
      cycle(16'h8003, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_resp !== 16'h0002 || bus.o_nresp !== 16'h8001) begin
         n_errors++; $display("FAIL rr_8003 got %h/%h want 0002/8001", bus.o_resp, bus.o_nresp);
      end
      cycle('0, 1'b1, '0, '0);
      cycle('0, 1'b1, 16'h0002, '0);
      n_checks++;
      if (bus.o_owner_vld !== 1'b0 || bus.o_owner !== 4'd1) begin
         n_errors++; $display("FAIL rr_release got vld=%b owner=%0d want 0/1", bus.o_owner_vld, bus.o_owner);
      end
      cycle(16'h8001, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_resp !== 16'h8000 || bus.o_nresp !== 16'h0001) begin
         n_errors++; $display("FAIL rr_8001 got %h/%h want 8000/0001", bus.o_resp, bus.o_nresp);
      end
      cycle('0, 1'b1, 16'h8000, '0);
      n_checks++;
      if (bus.o_owner_vld !== 1'b0 || bus.o_owner !== 4'd15) begin
         n_errors++; $display("FAIL rr_owner_kept got vld=%b owner=%0d want 0/15", bus.o_owner_vld, bus.o_owner);
      end
   endtask

   task automatic test_busy_reject();
      cycle(16'h0020, 1'b1, '0, '0);
      cycle('0, 1'b1, '0, '0);
      cycle(16'h0010, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_nresp !== 16'h0010 || bus.o_resp !== 16'h0 || bus.o_owner !== 4'd5) begin
         n_errors++; $display("FAIL busy_reject got nresp=%h resp=%h owner=%0d want 0010/0000/5", bus.o_nresp, bus.o_resp, bus.o_owner);
      end
      cycle(16'h0020, 1'b1, 16'h0020, '0);
      n_checks++;
      if (bus.o_nresp !== 16'h0020 || bus.o_owner_vld !== 1'b0) begin
         n_errors++; $display("FAIL owner_req_with_eop got nresp=%h vld=%b want 0020/0", bus.o_nresp, bus.o_owner_vld);
      end
      cycle(16'h0010, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_resp !== 16'h0010 || bus.o_owner !== 4'd4) begin
         n_errors++; $display("FAIL rerequest got resp=%h owner=%0d want 0010/4", bus.o_resp, bus.o_owner);
      end
      cycle('0, 1'b1, 16'h0010, '0);
   endtask

   task automatic test_not_ready();
      cycle(16'hFFFF, 1'b0, '0, '0);
      n_checks++;
      if (bus.o_nresp !== 16'hFFFF || bus.o_resp !== 16'h0 || bus.o_owner_vld !== 1'b0) begin
         n_errors++; $display("FAIL not_ready got nresp=%h resp=%h vld=%b want FFFF/0000/0", bus.o_nresp, bus.o_resp, bus.o_owner_vld);
      end
      cycle(16'hFFFF, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_resp !== 16'h0020 || bus.o_nresp !== 16'hFFDF) begin
         n_errors++; $display("FAIL ptr_held got resp=%h nresp=%h want 0020/FFDF", bus.o_resp, bus.o_nresp);
      end
      cycle('0, 1'b1, 16'h0020, '0);
   endtask

   task automatic test_eop_nonowner_and_reset();
      cycle(16'h0040, 1'b1, '0, '0);
      cycle('0, 1'b1, 16'h0008, '0);
      cycle('0, 1'b1, 16'h0008, '0);
      n_checks++;
      if (bus.o_owner_vld !== 1'b1 || bus.o_owner !== 4'd6) begin
         n_errors++; $display("FAIL nonowner_eop got vld=%b owner=%0d want 1/6", bus.o_owner_vld, bus.o_owner);
      end
      do_reset();
      n_checks++;
      if ({bus.o_resp, bus.o_nresp, bus.o_owner, bus.o_owner_vld, bus.o_wdog_err} !== 38'h0) begin
         n_errors++; $display("FAIL mid_packet_reset got resp=%h nresp=%h owner=%0d vld=%b want all 0", bus.o_resp, bus.o_nresp, bus.o_owner, bus.o_owner_vld);
      end
      cycle(16'hFFFF, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_resp !== 16'h0001 || bus.o_owner !== 4'd0) begin
         n_errors++; $display("FAIL post_reset_grant got resp=%h owner=%0d want 0001/0", bus.o_resp, bus.o_owner);
      end
      cycle('0, 1'b1, 16'h0001, '0);
   endtask

   task automatic test_watchdog();
      cycle(16'h0004, 1'b1, '0, '0);
`ifdef OUT_ARB_WDOG_EN
      for (int i = 1; i <= WD + 1; i++) begin
         cycle('0, 1'b1, '0, '0);
         n_checks++;
         if (bus.o_owner_vld !== e_vld || bus.o_wdog_err !== e_err) begin
            n_errors++; $display("FAIL wdog_step%0d got vld=%b err=%b want %b/%b", i, bus.o_owner_vld, bus.o_wdog_err, e_vld, e_err);
         end
      end
      n_checks++;
      if (bus.o_wdog_err !== 1'b1 || bus.o_owner_vld !== 1'b0) begin
         n_errors++; $display("FAIL wdog_fire got err=%b vld=%b want 1/0", bus.o_wdog_err, bus.o_owner_vld);
      end
      cycle('0, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_wdog_err !== 1'b0) begin
         n_errors++; $display("FAIL wdog_pulse_len got err=%b want 0", bus.o_wdog_err);
      end
`else
      for (int i = 0; i < 1000; i++) cycle('0, 1'b1, '0, '0);
      n_checks++;
      if (bus.o_owner_vld !== 1'b1 || bus.o_wdog_err !== 1'b0 || bus.o_owner !== 4'd2) begin
         n_errors++; $display("FAIL lock_held got vld=%b err=%b owner=%0d want 1/0/2", bus.o_owner_vld, bus.o_wdog_err, bus.o_owner);
      end
      cycle('0, 1'b1, 16'h0004, '0);
      n_checks++;
      if (bus.o_owner_vld !== 1'b0) begin
         n_errors++; $display("FAIL lock_release got vld=%b want 0", bus.o_owner_vld);
      end
`endif
   endtask

   task automatic test_random();
      logic [PN-1:0] req, eop, dvld;
      logic          rdy;
      for (int i = 0; i < 500; i++) begin
         req  = ($urandom_range(0, 2) == 0) ? PN'($urandom & $urandom) : '0;
         rdy  = ($urandom_range(0, 3) != 0);
         eop  = ($urandom_range(0, 5) == 0) ? PN'($urandom) : '0;
         dvld = ((i / 16) % 2 == 0) ? PN'($urandom) : '0;
         cycle(req, rdy, eop, dvld);
         n_checks++;
         if ({bus.o_resp, bus.o_nresp, bus.o_owner, bus.o_owner_vld, bus.o_wdog_err} !==
             {e_resp, e_nresp, e_owner, e_vld, e_err}) begin
            n_errors++;
            $display("FAIL random_cyc%0d got resp=%h nresp=%h owner=%0d vld=%b err=%b want %h %h %0d %b %b",
                     i, bus.o_resp, bus.o_nresp, bus.o_owner, bus.o_owner_vld, bus.o_wdog_err,
                     e_resp, e_nresp, e_owner, e_vld, e_err);
         end
      end
   endtask

   initial begin
      bus.i_req = '0; bus.i_port_ready = 1'b0; bus.i_eop = '0; bus.i_data_vld = '0;
      model_reset();
      test_reset();
      test_first_grant();
      test_rr_priority();
      test_busy_reject();
      test_not_ready();
      test_eop_nonowner_and_reset();
      test_watchdog();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
